// File: rtl/mem_seq_arb.sv
// mem_seq_arb -- bus arbiter and memory-cycle sequencer.
//
// Grants one of NREQ masters (fixed priority or round-robin), then runs one
// ROM / DRAM / IO / internal cycle for it with per-region wait states. A DRAM
// row is left open after a DRAM cycle so a following access to the same row
// skips the row open. Refresh requests are taken in IDLE ahead of bus requests.
//
// Ports:
//   clk      in   system clock, all state on rising edge
//   reset    in   asynchronous active-high reset
//   req      in   [NREQ] level bus requests, held until ack
//   rr_mode  in   0 = fixed priority (highest index wins), 1 = round-robin
//   region   in   [2] region of the granted cycle: 0 ROM, 1 DRAM, 2 IO, 3 internal
//   rwin     in   1 = read, 0 = write
//   match    in   row address equals the open DRAM row
//   spd      in   [4*WCNTW] wait count per region, field r = spd[r*WCNTW +: WCNTW]
//   waitl    in   active-low external wait, extends an access
//   refreq   in   level refresh request, held until refack
//   gnt      out  [NREQ] one-hot grant, GRANT..ACK
//   ack      out  one-cycle cycle-complete pulse
//   refack   out  one-cycle refresh-complete pulse
//   busy     out  sequencer not idle
//   romcsl, iocsl, rasl, casl, oel, wel  out  active-low strobes
module mem_seq_arb #(
  parameter int NREQ   = 4,
  parameter int RASCYC = 2,
  parameter int REFCYC = 4,
  parameter int WCNTW  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic                 rr_mode,
  input  logic [1:0]           region,
  input  logic                 rwin,
  input  logic                 match,
  input  logic [4*WCNTW-1:0]   spd,
  input  logic                 waitl,
  input  logic                 refreq,
  output logic [NREQ-1:0]      gnt,
  output logic                 ack,
  output logic                 refack,
  output logic                 busy,
  output logic                 romcsl,
  output logic                 iocsl,
  output logic                 rasl,
  output logic                 casl,
  output logic                 oel,
  output logic                 wel
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMAX = (RASCYC > REFCYC) ? RASCYC : REFCYC;
  localparam int TW   = $clog2(TMAX + 1);
  // One counter times RAS, REFRESH and ACCESS, so it covers the widest use.
  localparam int CW   = (WCNTW > TW) ? WCNTW : TW;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_PRE, S_RAS, S_ACCESS, S_ACK, S_REFRESH
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      region_q, region_d;
  logic            rwin_q, rwin_d;
  logic            page_q, page_d;
  logic            preref_q, preref_d;
  logic            ack_q, ack_d;
  logic            refack_q, refack_d;
  logic            busy_q, busy_d;
  logic            romcsl_q, romcsl_d;
  logic            iocsl_q, iocsl_d;
  logic            rasl_q, rasl_d;
  logic            casl_q, casl_d;
  logic            oel_q, oel_d;
  logic            wel_q, wel_d;

  logic [PW-1:0]   win;
  logic [1:0]      reg_eff;
  logic            rwin_eff;
  logic            acc;

  // Fixed priority: highest asserted index. Round-robin: first asserted index
  // at or above the pointer, wrapping. Loops run so the preferred hit is last.
  function automatic logic [PW-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                input logic rr,
                                                input logic [PW-1:0] p);
    logic [PW-1:0] w;
    int            idx;
    w = '0;
    if (!rr) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r[i]) w = PW'(i);
      end
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = (int'(p) + k) % NREQ;
        if (r[idx]) w = PW'(idx);
      end
    end
    return w;
  endfunction

  function automatic logic [CW-1:0] spd_field(input logic [4*WCNTW-1:0] s,
                                              input logic [1:0] r);
    return CW'(s[int'(r)*WCNTW +: WCNTW]);
  endfunction

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    region_d = region_q;
    rwin_d   = rwin_q;
    page_d   = page_q;
    preref_d = preref_q;

    win = pick_winner(req, rr_mode, ptr_q);

    // Region/direction are live inputs during GRANT and latched afterwards.
    reg_eff  = (state_q == S_GRANT) ? region : region_q;
    rwin_eff = (state_q == S_GRANT) ? rwin : rwin_q;

    case (state_q)
      S_IDLE: begin
        if (refreq) begin
          // Refresh always goes through PRE so the open row is closed first.
          state_d  = S_PRE;
          preref_d = 1'b1;
          page_d   = 1'b0;
        end else if (|req) begin
          state_d  = S_GRANT;
          gnt_d    = '0;
          gnt_d[win] = 1'b1;
          ptr_d    = PW'((int'(win) + 1) % NREQ);
        end
      end
      S_GRANT: begin
        region_d = region;
        rwin_d   = rwin;
        preref_d = 1'b0;
        if (region == 2'd1) begin
          if (page_q && match) begin
            state_d = S_ACCESS;
            cnt_d   = spd_field(spd, region);
          end else if (page_q) begin
            state_d = S_PRE;
            page_d  = 1'b0;
          end else begin
            state_d = S_RAS;
            cnt_d   = CW'(RASCYC - 1);
            page_d  = 1'b1;
          end
        end else begin
          state_d = S_ACCESS;
          cnt_d   = spd_field(spd, region);
        end
      end
      S_PRE: begin
        if (preref_q) begin
          state_d = S_REFRESH;
          cnt_d   = CW'(REFCYC - 1);
        end else begin
          state_d = S_RAS;
          cnt_d   = CW'(RASCYC - 1);
          page_d  = 1'b1;
        end
      end
      S_RAS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_ACCESS;
          cnt_d   = spd_field(spd, region_q);
        end
      end
      S_ACCESS: begin
        // Internal cycles are always a single ACCESS cycle.
        if (region_q == 2'd3) begin
          state_d = S_ACK;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (waitl) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      S_REFRESH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    acc      = (state_d == S_ACCESS);
    ack_d    = (state_d == S_ACK);
    refack_d = (state_d == S_REFRESH) && (cnt_d == '0);
    busy_d   = (state_d != S_IDLE);
    romcsl_d = !(acc && reg_eff == 2'd0);
    iocsl_d  = !(acc && reg_eff == 2'd2);
    casl_d   = !(acc && reg_eff == 2'd1);
    oel_d    = !(acc && reg_eff != 2'd3 && rwin_eff);
    wel_d    = !(acc && (reg_eff == 2'd1 || reg_eff == 2'd2) && !rwin_eff);
    // RAS stays low while a row is held open, except during PRE.
    rasl_d   = !((state_d == S_RAS) || (state_d == S_REFRESH) ||
                 (page_d && state_d != S_PRE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      region_q <= 2'd0;
      rwin_q   <= 1'b0;
      page_q   <= 1'b0;
      preref_q <= 1'b0;
      ack_q    <= 1'b0;
      refack_q <= 1'b0;
      busy_q   <= 1'b0;
      romcsl_q <= 1'b1;
      iocsl_q  <= 1'b1;
      rasl_q   <= 1'b1;
      casl_q   <= 1'b1;
      oel_q    <= 1'b1;
      wel_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      region_q <= region_d;
      rwin_q   <= rwin_d;
      page_q   <= page_d;
      preref_q <= preref_d;
      ack_q    <= ack_d;
      refack_q <= refack_d;
      busy_q   <= busy_d;
      romcsl_q <= romcsl_d;
      iocsl_q  <= iocsl_d;
      rasl_q   <= rasl_d;
      casl_q   <= casl_d;
      oel_q    <= oel_d;
      wel_q    <= wel_d;
    end
  end

  assign gnt    = gnt_q;
  assign ack    = ack_q;
  assign refack = refack_q;
  assign busy   = busy_q;
  assign romcsl = romcsl_q;
  assign iocsl  = iocsl_q;
  assign rasl   = rasl_q;
  assign casl   = casl_q;
  assign oel    = oel_q;
  assign wel    = wel_q;

endmodule

// File: tb/tb_mem_seq_arb.sv
// Directed bench for mem_seq_arb: arbitration, DRAM page handling, refresh,
// external wait and reset behaviour with hand-computed cycle counts.
module tb_mem_seq_arb;

  localparam int NREQ  = 4;
  localparam int WCNTW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic              rr_mode;
  logic [1:0]        region;
  logic              rwin;
  logic              match;
  logic [4*WCNTW-1:0] spd;
  logic              waitl;
  logic              refreq;
  logic [NREQ-1:0]   gnt;
  logic              ack, refack, busy;
  logic              romcsl, iocsl, rasl, casl, oel, wel;
  logic [5:0]        strb;

  int n_cmp = 0;
  int n_bad = 0;

  mem_seq_arb #(.NREQ(NREQ), .RASCYC(2), .REFCYC(4), .WCNTW(WCNTW)) dut (
    .clk(clk), .reset(reset), .req(req), .rr_mode(rr_mode), .region(region),
    .rwin(rwin), .match(match), .spd(spd), .waitl(waitl), .refreq(refreq),
    .gnt(gnt), .ack(ack), .refack(refack), .busy(busy), .romcsl(romcsl),
    .iocsl(iocsl), .rasl(rasl), .casl(casl), .oel(oel), .wel(wel)
  );

  always #5 clk = ~clk;

  // bit 5 romcsl, 4 iocsl, 3 rasl, 2 casl, 1 oel, 0 wel
  assign strb = {romcsl, iocsl, rasl, casl, oel, wel};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Steps negedges until a grant shows; returns the number of cycles waited.
  task automatic wait_gnt(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt == '0 && waited < 20);
    check_eq("gnt_seen", 32'(gnt != '0), 32'd1);
  endtask

  // Called at the GRANT negedge; runs to the ACK negedge. tot counts GRANT..ACK,
  // the other counts cover the cycles strictly between GRANT and ACK.
  task automatic measure(input logic [5:0] mask, output int tot, output int n_sel,
                         output int n_ras, output int n_pre);
    tot = 1; n_sel = 0; n_ras = 0; n_pre = 0;
    while (tot < 40) begin
      @(negedge clk);
      tot++;
      if (ack) break;
      if ((strb & mask) == 6'd0) n_sel++;
      if (!rasl && casl) n_ras++;
      if (rasl && busy) n_pre++;
    end
    check_eq("ack_seen", 32'(ack), 32'd1);
  endtask

  initial begin
    int w, tot, ns, nr, np, n, n_ack;
    logic [NREQ-1:0] e;

    reset = 1'b1; req = '0; rr_mode = 1'b0; region = 2'd0; rwin = 1'b1;
    match = 1'b0; spd = '0; waitl = 1'b1; refreq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_ack", 32'({ack, refack, busy}), 32'd0);
    check_eq("rst_strb", 32'(strb), 32'h3F);
    reset = 1'b0;

    // Fixed priority, ROM read, spd=2
    spd = 16'h0002; region = 2'd0; rwin = 1'b1; rr_mode = 1'b0; req = 4'b0101;
    wait_gnt(w);
    check_eq("fp_lat", 32'(w), 32'd1);
    check_eq("fp_gnt1", 32'(gnt), 32'b0100);
    check_eq("fp_busy", 32'(busy), 32'd1);
    measure(6'b100010, tot, ns, nr, np);
    check_eq("fp_len1", 32'(tot), 32'd5);
    check_eq("fp_rom_low", 32'(ns), 32'd3);
    req = req & ~gnt;
    @(negedge clk);
    check_eq("fp_idle", 32'({gnt, ack, busy}), 32'd0);
    wait_gnt(w);
    check_eq("fp_gnt2", 32'(gnt), 32'b0001);
    measure(6'b100010, tot, ns, nr, np);
    check_eq("fp_len2", 32'(tot), 32'd5);
    req = '0;

    // Round-robin, internal cycles, all requesting
    pulse_reset();
    rr_mode = 1'b1; region = 2'd3; req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(w);
      e = 4'(1 << (k % 4));
      check_eq("rr_gnt", 32'(gnt), 32'(e));
      measure(6'h3F, tot, ns, nr, np);
      check_eq("rr_len", 32'(tot), 32'd3);
    end
    req = '0;

    // DRAM page handling
    pulse_reset();
    rr_mode = 1'b0; region = 2'd1; rwin = 1'b0; match = 1'b0; spd = 16'h0010;
    req = 4'b0001;
    wait_gnt(w);
    check_eq("dm_rasl_grant", 32'(rasl), 32'd1);
    measure(6'b000101, tot, ns, nr, np);
    check_eq("dm_len", 32'(tot), 32'd6);
    check_eq("dm_ras", 32'(nr), 32'd2);
    check_eq("dm_pre", 32'(np), 32'd0);
    check_eq("dm_caswe", 32'(ns), 32'd2);
    check_eq("dm_rasl_open", 32'(rasl), 32'd0);
    req = '0;
    @(negedge clk);
    rwin = 1'b1; match = 1'b1; req = 4'b0001;
    wait_gnt(w);
    measure(6'b000110, tot, ns, nr, np);
    check_eq("dh_len", 32'(tot), 32'd4);
    check_eq("dh_ras", 32'(nr), 32'd0);
    check_eq("dh_pre", 32'(np), 32'd0);
    check_eq("dh_casoe", 32'(ns), 32'd2);
    req = '0;
    @(negedge clk);
    match = 1'b0; req = 4'b0001;
    wait_gnt(w);
    measure(6'b000110, tot, ns, nr, np);
    check_eq("do_len", 32'(tot), 32'd7);
    check_eq("do_pre", 32'(np), 32'd1);
    check_eq("do_ras", 32'(nr), 32'd2);
    check_eq("do_casoe", 32'(ns), 32'd2);
    check_eq("do_rasl_open", 32'(rasl), 32'd0);
    req = '0;
    @(negedge clk);

    // Refresh and request together in IDLE
    refreq = 1'b1; req = 4'b0001; region = 2'd3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check_eq("rf_pre", 32'({rasl, busy, gnt}), 32'h30);
    end while (!refack && n < 20);
    check_eq("rf_len", 32'(n), 32'd5);
    check_eq("rf_gnt", 32'(gnt), 32'd0);
    check_eq("rf_rasl", 32'(rasl), 32'd0);
    refreq = 1'b0;
    wait_gnt(w);
    check_eq("rf_wait", 32'(w), 32'd2);
    check_eq("rf_gnt_after", 32'(gnt), 32'b0001);
    check_eq("rf_page_closed", 32'(rasl), 32'd1);
    measure(6'h3F, tot, ns, nr, np);
    check_eq("rf_cyc_len", 32'(tot), 32'd3);
    req = '0;
    @(negedge clk);

    // IO read with external wait
    region = 2'd2; rwin = 1'b1; spd = 16'h0100; waitl = 1'b0; req = 4'b0001;
    wait_gnt(w);
    n = 0;
    @(negedge clk);
    while (!iocsl && !oel && n < 20) begin
      n++;
      if (n == 5) waitl = 1'b1;
      @(negedge clk);
    end
    waitl = 1'b1;
    check_eq("wt_low", 32'(n), 32'd5);
    check_eq("wt_ack", 32'(ack), 32'd1);
    req = '0;
    @(negedge clk);

    // Reset in the middle of a DRAM access
    region = 2'd1; rwin = 1'b0; match = 1'b0; spd = 16'h0030; req = 4'b0001;
    wait_gnt(w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (casl && n < 20);
    check_eq("rm_in_access", 32'(casl), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("rm_gnt", 32'(gnt), 32'd0);
    check_eq("rm_strb", 32'(strb), 32'h3F);
    check_eq("rm_busy", 32'({busy, ack}), 32'd0);
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    check_eq("rm_no_ack", 32'(n_ack), 32'd0);
    match = 1'b1; rwin = 1'b1; req = 4'b0001;
    wait_gnt(w);
    measure(6'b000110, tot, ns, nr, np);
    check_eq("rm_len", 32'(tot), 32'd8);
    check_eq("rm_ras", 32'(nr), 32'd2);
    check_eq("rm_casoe", 32'(ns), 32'd4);
    req = '0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_seq_arb.md
# mem_seq_arb

Parametrised bus arbiter and memory-cycle sequencer for the Jaguar memory subsystem. Arbitrates NREQ bus masters (fixed-priority or round-robin), runs one ROM / DRAM / IO / internal cycle per grant with per-region programmable wait states, keeps a DRAM page open across cycles, and interleaves refresh. It generalises the fixed-channel memory controller with configurable channel count, an arbitration mode and page-mode DRAM.

## Interface
Parameters:
- NREQ, 4, number of requesting masters (2..8)
- RASCYC, 2, RAS-to-CAS cycles for a row open
- REFCYC, 4, cycles RAS is held low for a refresh
- WCNTW, 4, wait-counter width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req  in  NREQ  level bus requests, held until ack
- rr_mode  in  1  0 = fixed priority (req[NREQ-1] highest), 1 = round-robin
- region  in  2  region of granted master's cycle: 0 ROM, 1 DRAM, 2 IO, 3 internal
- rwin  in  1  1 = read, 0 = write (granted master)
- match  in  1  row address equals open DRAM row
- spd  in  4*WCNTW  wait count per region, field r = spd[r*WCNTW +: WCNTW]
- waitl  in  1  active-low external wait, extends access
- refreq  in  1  level refresh request, held until refack
- gnt  out  NREQ  one-hot grant
- ack  out  1  one-cycle cycle-complete pulse
- refack  out  1  one-cycle refresh-complete pulse
- busy  out  1  state != IDLE
- romcsl, iocsl, rasl, casl, oel, wel  out  1 each  active-low strobes

## Operation
- States: IDLE, GRANT, PRE, RAS, ACCESS, ACK, REFRESH.
- IDLE: refreq wins over any req -> REFRESH (closes page: rasl high 1 cycle via PRE, then low REFCYC cycles, refack in last cycle) -> IDLE. Else any req -> GRANT with winner registered into gnt.
- Fixed priority: highest asserted index. Round-robin: first asserted index at or above pointer, wrapping; pointer <= winner+1 mod NREQ on each grant. Pointer resets to 0.
- GRANT (1 cycle): latch region, rwin, match. DRAM with page open and match=1 -> ACCESS. DRAM otherwise -> PRE (only if page open) -> RAS. Non-DRAM -> ACCESS.
- PRE: rasl high 1 cycle, page closed. RAS: rasl low RASCYC cycles, page open.
- ACCESS: counter loaded with spd[region]; stays while counter != 0, decrementing; at 0 also stays while waitl=0. Region 3 ignores spd and waitl: exactly 1 cycle.
- Strobes in ACCESS: ROM romcsl=0, oel=!rwin; IO iocsl=0, oel=!rwin, wel=rwin; DRAM casl=0, oel=!rwin, wel=rwin. rasl stays low after a DRAM cycle while page open.
- ACK: ack=1 one cycle, gnt held; gnt cleared on exit -> IDLE. req dropping mid-cycle does not abort; ack still issued.
- gnt one-hot throughout GRANT..ACK, zero otherwise.

## Timing
- Reset values: gnt=0, ack=0, refack=0, busy=0, all strobes=1, page closed, pointer=0, state IDLE. Reset mid-cycle returns everything immediately; no ack.
- req to gnt: 1 cycle. Cycle length gnt-to-ack-deassert: ROM/IO 1+(spd+1)+1; DRAM page hit same; DRAM miss adds RASCYC (+1 if page was open); internal 3.
- All outputs registered; strobes change only on state transitions.
- New grant earliest cycle after ACK (one IDLE cycle between cycles).
- refreq arriving during a cycle is serviced at next IDLE ahead of pending req.
- spd=0: ACCESS lasts 1 cycle (plus waitl extension).

## Test plan
- Fixed priority: req=4'b0101, rr_mode=0, region=0, spd=2 -> gnt=4'b0100, romcsl low 3 cycles, ack 1 cycle later; then gnt=4'b0001.
- Round-robin: req=4'b1111 held, rr_mode=1, region 3 -> grant order 0,1,2,3,0 each cycle 3 clocks apart.
- DRAM page: write miss (page closed) RASCYC=2 -> rasl low 2 cycles before casl; next read match=1 -> no RAS, casl straight after GRANT; next match=0 -> rasl high 1 cycle (PRE) then RAS.
- Refresh collision: refreq and req=4'b0001 rise same cycle in IDLE -> REFRESH first, refack after PRE+4 cycles, then gnt=4'b0001.
- waitl: IO read spd=1, waitl=0 for 3 extra cycles -> iocsl/oel low 5 cycles, ack after waitl rises.
- Reset mid DRAM access: assert reset in ACCESS -> gnt=0, strobes high, ack never pulses, page closed.
